// File: rtl/fifo36e2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo36e2_pkg
// Description : Shared constants, the stored word type and an occupancy
//               helper for the 512 x 72 first-word-fall-through FIFO.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fifo36e2_pkg;

  localparam int DATA_W            = 64;
  localparam int PAR_W             = 8;
  localparam int DEPTH             = 512;
  localparam int CNT_W             = 14;
  localparam int AW                = $clog2(DEPTH);
  localparam int PROG_FULL_THRESH  = 256;
  localparam int PROG_EMPTY_THRESH = 128;
  localparam int RSTBUSY_CYC       = 4;
  localparam int RB_W              = $clog2(RSTBUSY_CYC + 1);

  // Count-width versions of the thresholds so flag compares are width-exact.
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PFULL_CNT  = CNT_W'(PROG_FULL_THRESH);
  localparam logic [CNT_W-1:0] PEMPTY_CNT = CNT_W'(PROG_EMPTY_THRESH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PAR_W-1:0]  par;
  } word_t;

  // Value presented on DOUT/DOUTP out of reset.
  localparam word_t SRVAL = '0;

  // Occupancy update: +1 on inc only, -1 on dec only, unchanged otherwise.
  function automatic logic [CNT_W-1:0] occ_next(input logic [CNT_W-1:0] occ,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] r;
    r = occ;
    if (inc && !dec) begin
      r = occ + CNT_W'(1);
    end else if (dec && !inc) begin
      r = occ - CNT_W'(1);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo36e2_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo36e2_if
// Description : Producer/consumer bundle of the FIFO. The master modport is
//               the user side (drives strobes/data), the slave modport is the
//               FIFO side (drives data out, flags, counts, error strobes).
// Signals     : sleep, wren, din, dinp, rden            (master -> slave)
//               rstbusy, full, progfull, wrcount, wrerr,
//               dout, doutp, empty, progempty, rdcount,
//               rderr                                     (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo36e2_if;
  import fifo36e2_pkg::*;

  logic              sleep;
  logic              wren;
  logic [DATA_W-1:0] din;
  logic [PAR_W-1:0]  dinp;
  logic              rden;

  logic              rstbusy;
  logic              full;
  logic              progfull;
  logic [CNT_W-1:0]  wrcount;
  logic              wrerr;
  logic [DATA_W-1:0] dout;
  logic [PAR_W-1:0]  doutp;
  logic              empty;
  logic              progempty;
  logic [CNT_W-1:0]  rdcount;
  logic              rderr;

  modport master (
    output sleep, wren, din, dinp, rden,
    input  rstbusy, full, progfull, wrcount, wrerr,
           dout, doutp, empty, progempty, rdcount, rderr
  );

  modport slave (
    input  sleep, wren, din, dinp, rden,
    output rstbusy, full, progfull, wrcount, wrerr,
           dout, doutp, empty, progempty, rdcount, rderr
  );

endinterface
`default_nettype wire

// File: rtl/fifo36e2_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo36e2_ram
// Description : Simple dual-port DEPTH x (DATA_W+PAR_W) RAM, one write port
//               and one synchronous read port with read enable. The read
//               register holds its value while re_i is low and resets to
//               SRVAL; the array itself is not reset.
// Ports       : clk_i, rst_ni          clock / async active-low reset
//               we_i, waddr_i, wdata_i write port
//               re_i, raddr_i, rdata_o registered read port
// Revision    : 1.0 - initial release
// ============================================================================
module fifo36e2_ram
  import fifo36e2_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);

  word_t mem_q [DEPTH];
  word_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= SRVAL;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fifo36e2_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo36e2_sync
// Description : Single-clock 512 x 72 first-word-fall-through FIFO with
//               full/empty, programmable thresholds, occupancy counts,
//               error strobes, sleep and reset-busy.
// Ports       : clk_i   rising-edge clock
//               rst_ni  asynchronous active-low reset
//               bus     fifo36e2_if.slave (strobes, data, flags, counts)
// Config      : FIFO36E2_DOREG_EN defined -> extra output register stage,
//               first-word latency 2. Undefined -> first-word latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo36e2_sync
  import fifo36e2_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  fifo36e2_if.slave bus
);

  // Pointers and counts. count_q is the user-visible occupancy (every stored
  // word, including the one on DOUT). ram_cnt_q counts words still in the
  // array that have not been fetched into the read pipeline yet.
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    fetch_ptr_q, fetch_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] ram_cnt_q, ram_cnt_d;
  logic [RB_W-1:0]  rb_cnt_q, rb_cnt_d;
  logic             rstbusy_q, rstbusy_d;

  logic             full_q, full_d;
  logic             progfull_q, progfull_d;
  logic             progempty_q, progempty_d;
  logic             wrerr_q, wrerr_d;
  logic             rderr_q, rderr_d;
  logic             head_valid_q, head_valid_d;

  logic             adv;
  logic             ops_en;
  logic             wr_acc;
  logic             rd_acc;
  logic             fetch;
  logic             take;
  logic             ram_nonempty;
  word_t            wr_word;
  word_t            ram_rdata;
  word_t            dout_w;

  // Sleep freezes the whole datapath; reset-busy only blocks user strobes.
  assign adv          = ~bus.sleep;
  assign ops_en       = adv & ~rstbusy_q;
  assign wr_acc       = ops_en & bus.wren & ~full_q;
  assign rd_acc       = ops_en & bus.rden & head_valid_q;
  assign ram_nonempty = (ram_cnt_q != '0);

  assign wr_word.data = bus.din;
  assign wr_word.par  = bus.dinp;

  fifo36e2_ram u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_word),
    .re_i    (fetch),
    .raddr_i (fetch_ptr_q),
    .rdata_o (ram_rdata)
  );

`ifdef FIFO36E2_DOREG_EN
  // Two-stage prefetch: the RAM read register is stage 1, out_q is the
  // visible head. Stage 1 refills whenever it is empty or moves forward, so
  // back-to-back pops still see a new head every cycle.
  logic  s1_valid_q, s1_valid_d;
  word_t out_q, out_d;

  assign take         = adv & (~head_valid_q | rd_acc);
  assign fetch        = adv & (~s1_valid_q | take) & ram_nonempty;
  assign s1_valid_d   = fetch | (s1_valid_q & ~take);
  assign head_valid_d = take ? s1_valid_q : head_valid_q;
  // Load only real words so DOUT holds its last value once drained.
  assign out_d        = (take & s1_valid_q) ? ram_rdata : out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      out_q      <= SRVAL;
    end else begin
      s1_valid_q <= s1_valid_d;
      out_q      <= out_d;
    end
  end

  assign dout_w = out_q;
`else
  // The RAM read register is the head. A word can be fetched only one edge
  // after it was written (ram_cnt_q is registered), which gives the one-cycle
  // first-word latency and avoids read-during-write on the same address.
  assign take         = adv & (~head_valid_q | rd_acc);
  assign fetch        = take & ram_nonempty;
  assign head_valid_d = take ? fetch : head_valid_q;
  assign dout_w       = ram_rdata;
`endif

  // Next-state for pointers, counts and flags.
  assign wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign fetch_ptr_d = fetch ? fetch_ptr_q + AW'(1) : fetch_ptr_q;
  assign count_d     = occ_next(count_q, wr_acc, rd_acc);
  assign ram_cnt_d   = occ_next(ram_cnt_q, wr_acc, fetch);

  // Flags are derived from the next count so they change on the same edge
  // as the occupancy itself.
  assign full_d      = (count_d == DEPTH_CNT);
  assign progfull_d  = (count_d >= PFULL_CNT);
  assign progempty_d = (count_d < PEMPTY_CNT);
  assign wrerr_d     = ops_en & bus.wren & full_q;
  assign rderr_d     = ops_en & bus.rden & ~head_valid_q;

  // Reset-busy counts down from RSTBUSY_CYC after reset release and keeps
  // running during sleep so reset sequencing is independent of it.
  assign rb_cnt_d  = (rb_cnt_q != '0) ? rb_cnt_q - RB_W'(1) : rb_cnt_q;
  assign rstbusy_d = (rb_cnt_d != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      count_q      <= '0;
      ram_cnt_q    <= '0;
      rb_cnt_q     <= RB_W'(RSTBUSY_CYC);
      rstbusy_q    <= 1'b1;
      full_q       <= 1'b0;
      progfull_q   <= 1'b0;
      progempty_q  <= 1'b1;
      wrerr_q      <= 1'b0;
      rderr_q      <= 1'b0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      count_q      <= count_d;
      ram_cnt_q    <= ram_cnt_d;
      rb_cnt_q     <= rb_cnt_d;
      rstbusy_q    <= rstbusy_d;
      full_q       <= full_d;
      progfull_q   <= progfull_d;
      progempty_q  <= progempty_d;
      wrerr_q      <= wrerr_d;
      rderr_q      <= rderr_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign bus.rstbusy   = rstbusy_q;
  assign bus.full      = full_q;
  assign bus.progfull  = progfull_q;
  assign bus.wrcount   = count_q;
  assign bus.wrerr     = wrerr_q;
  assign bus.dout      = dout_w.data;
  assign bus.doutp     = dout_w.par;
  assign bus.empty     = ~head_valid_q;
  assign bus.progempty = progempty_q;
  assign bus.rdcount   = count_q;
  assign bus.rderr     = rderr_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo36e2_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo36e2_sync
// Description : Directed self-checking bench for fifo36e2_sync (default,
//               unregistered-output build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo36e2_sync;
  import fifo36e2_pkg::*;

  localparam logic [63:0] BASE  = 64'hFEDCBA98_76543210;
  localparam logic [63:0] BASE2 = 64'h01234567_89AB0000;
  localparam logic [63:0] BASE3 = 64'h5A5A5A5A_00000000;
  localparam logic [63:0] JUNK  = 64'hDEADBEEF_DEADBEEF;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  fifo36e2_if bus_if ();

  fifo36e2_sync dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    bus_if.sleep = 1'b0;
    bus_if.wren  = 1'b0;
    bus_if.rden  = 1'b0;
    bus_if.din   = '0;
    bus_if.dinp  = '0;
    rst_n        = 1'b0;

    // ---------------- reset state ----------------
    #100;
    check_eq("rst_empty",     64'(bus_if.empty),     64'd1);
    check_eq("rst_progempty", 64'(bus_if.progempty), 64'd1);
    check_eq("rst_full",      64'(bus_if.full),      64'd0);
    check_eq("rst_progfull",  64'(bus_if.progfull),  64'd0);
    check_eq("rst_wrcount",   64'(bus_if.wrcount),   64'd0);
    check_eq("rst_rstbusy",   64'(bus_if.rstbusy),   64'd1);
    check_eq("rst_dout",      bus_if.dout,           64'd0);
    // Writes during reset-busy must be ignored.
    bus_if.wren = 1'b1;
    bus_if.din  = JUNK;
    rst_n       = 1'b1;
    tick; tick; tick;
    check_eq("rstbusy_held", 64'(bus_if.rstbusy), 64'd1);
    tick;
    check_eq("rstbusy_fall", 64'(bus_if.rstbusy), 64'd0);
    check_eq("busy_no_wr",   64'(bus_if.wrcount), 64'd0);
    check_eq("busy_no_err",  64'(bus_if.wrerr),   64'd0);

    // ---------------- fill 512 ----------------
    for (int i = 0; i < 512; i++) begin
      bus_if.wren = 1'b1;
      bus_if.din  = BASE + 64'(i);
      bus_if.dinp = 8'(i);
      tick;
      if (i == 0)   check_eq("fwft_lat_empty", 64'(bus_if.empty), 64'd1);
      if (i == 1) begin
        check_eq("fwft_head_empty", 64'(bus_if.empty), 64'd0);
        check_eq("fwft_head_dout",  bus_if.dout,       BASE);
      end
      if (i == 126) check_eq("pe_at127",   64'(bus_if.progempty), 64'd1);
      if (i == 127) check_eq("pe_at128",   64'(bus_if.progempty), 64'd0);
      if (i == 254) check_eq("pf_at255",   64'(bus_if.progfull),  64'd0);
      if (i == 255) check_eq("pf_at256",   64'(bus_if.progfull),  64'd1);
      if (i == 510) check_eq("full_at511", 64'(bus_if.full),      64'd0);
    end
    check_eq("full_at512", 64'(bus_if.full),    64'd1);
    check_eq("wrcount512", 64'(bus_if.wrcount), 64'd512);
    check_eq("rdcount512", 64'(bus_if.rdcount), 64'd512);

    // ---------------- overflow ----------------
    bus_if.din = JUNK;
    tick;
    check_eq("ovf_wrerr",   64'(bus_if.wrerr),   64'd1);
    check_eq("ovf_count",   64'(bus_if.wrcount), 64'd512);
    check_eq("ovf_head",    bus_if.dout,         BASE);
    // Full + simultaneous read/write: read wins, write rejected.
    bus_if.rden = 1'b1;
    tick;
    check_eq("full_rw_wrerr", 64'(bus_if.wrerr),   64'd1);
    check_eq("full_rw_rderr", 64'(bus_if.rderr),   64'd0);
    check_eq("full_rw_count", 64'(bus_if.wrcount), 64'd511);
    check_eq("full_rw_head",  bus_if.dout,         BASE + 64'd1);
    bus_if.wren = 1'b0;

    // ---------------- drain ----------------
    bad = 0;
    for (int i = 1; i < 512; i++) begin
      if (bus_if.dout !== BASE + 64'(i) || bus_if.doutp !== 8'(i) || bus_if.empty !== 1'b0)
        bad++;
      tick;
    end
    check_eq("rd_order",     64'(bad),            64'd0);
    check_eq("rd_empty",     64'(bus_if.empty),   64'd1);
    check_eq("rd_count0",    64'(bus_if.wrcount), 64'd0);
    check_eq("rd_pe_back",   64'(bus_if.progempty), 64'd1);
    tick;
    check_eq("udf_rderr",    64'(bus_if.rderr),   64'd1);
    check_eq("udf_dout_hold", bus_if.dout,        BASE + 64'd511);
    check_eq("udf_doutp_hold", 64'(bus_if.doutp), 64'd255);
    bus_if.rden = 1'b0;
    tick;
    check_eq("rderr_pulse",  64'(bus_if.rderr),   64'd0);

    // ---------------- move pointers so the next phase wraps ----------------
    bus_if.wren = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus_if.din = JUNK - 64'(i);
      tick;
    end
    bus_if.wren = 1'b0;
    bus_if.rden = 1'b1;
    for (int i = 0; i < 200; i++) tick;
    bus_if.rden = 1'b0;
    check_eq("preload_drain", 64'(bus_if.wrcount), 64'd0);

    // ---------------- steady simultaneous R/W at 300 ----------------
    bus_if.wren = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus_if.din = BASE2 + 64'(i);
      tick;
    end
    bus_if.wren = 1'b0;
    tick;
    check_eq("rw_start_count", 64'(bus_if.wrcount), 64'd300);
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      if (bus_if.dout !== BASE2 + 64'(j) || bus_if.wrcount !== 14'd300 || bus_if.empty !== 1'b0)
        bad++;
      bus_if.wren = 1'b1;
      bus_if.rden = 1'b1;
      bus_if.din  = BASE2 + 64'(300 + j);
      tick;
    end
    bus_if.wren = 1'b0;
    check_eq("rw_steady",  64'(bad),            64'd0);
    check_eq("rw_count",   64'(bus_if.wrcount), 64'd300);
    bad = 0;
    for (int j = 100; j < 250; j++) begin
      if (bus_if.dout !== BASE2 + 64'(j)) bad++;
      tick;
    end
    check_eq("wrap_order", 64'(bad),            64'd0);
    check_eq("wrap_count", 64'(bus_if.wrcount), 64'd150);

    // ---------------- async reset mid-transfer ----------------
    bus_if.wren = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_empty",   64'(bus_if.empty),     64'd1);
    check_eq("mid_rst_wrcount", 64'(bus_if.wrcount),   64'd0);
    check_eq("mid_rst_rdcount", 64'(bus_if.rdcount),   64'd0);
    check_eq("mid_rst_pe",      64'(bus_if.progempty), 64'd1);
    check_eq("mid_rst_busy",    64'(bus_if.rstbusy),   64'd1);
    check_eq("mid_rst_dout",    bus_if.dout,           64'd0);
    bus_if.wren = 1'b0;
    bus_if.rden = 1'b0;
    #2;
    rst_n = 1'b1;
    tick; tick; tick; tick;
    check_eq("mid_rst_busy_fall", 64'(bus_if.rstbusy), 64'd0);

    // ---------------- empty + simultaneous R/W ----------------
    bus_if.wren = 1'b1;
    bus_if.rden = 1'b1;
    bus_if.din  = BASE3;
    tick;
    check_eq("empty_rw_rderr", 64'(bus_if.rderr),   64'd1);
    check_eq("empty_rw_wrerr", 64'(bus_if.wrerr),   64'd0);
    check_eq("empty_rw_count", 64'(bus_if.wrcount), 64'd1);
    bus_if.rden = 1'b0;
    for (int i = 1; i < 5; i++) begin
      bus_if.din = BASE3 + 64'(i);
      tick;
    end
    bus_if.wren = 1'b0;
    tick;
    check_eq("pre_sleep_head",  bus_if.dout,         BASE3);
    check_eq("pre_sleep_count", 64'(bus_if.wrcount), 64'd5);

    // ---------------- sleep freezes state ----------------
    bus_if.sleep = 1'b1;
    bus_if.wren  = 1'b1;
    bus_if.rden  = 1'b1;
    bus_if.din   = JUNK;
    tick; tick; tick;
    check_eq("sleep_count", 64'(bus_if.wrcount), 64'd5);
    check_eq("sleep_head",  bus_if.dout,         BASE3);
    check_eq("sleep_wrerr", 64'(bus_if.wrerr),   64'd0);
    check_eq("sleep_rderr", 64'(bus_if.rderr),   64'd0);
    check_eq("sleep_empty", 64'(bus_if.empty),   64'd0);
    bus_if.sleep = 1'b0;
    bus_if.wren  = 1'b0;
    tick;
    check_eq("wake_pop_head",  bus_if.dout,         BASE3 + 64'd1);
    check_eq("wake_pop_count", 64'(bus_if.wrcount), 64'd4);
    bus_if.rden = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
